// File: rtl/regfile_dbg_pkg.sv
// ============================================================================
// Module : regfile_dbg_pkg
// Brief  : Shared definitions for the debug register file: default sizes and
//          dump FSM state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_dbg_pkg;

  // Default geometry, reused by the datapath top
  localparam int unsigned C_DEF_XLEN  = 32;
  localparam int unsigned C_DEF_NREGS = 32;
  localparam int unsigned C_DEF_NRD   = 2;

  // Dump FSM state codes
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage : regfile_dbg_pkg

`default_nettype wire

// File: rtl/regfile_dbg_if.sv
// ============================================================================
// Module : regfile_dbg_if
// Brief  : Bus bundle of the debug register file: write port, packed read
//          ports and the valid/ready register dump stream.
//          master = datapath/consumer side, slave = register file side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_dbg_if #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  localparam int ADDR_W = $clog2(NREGS)
);

  // Write port
  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [XLEN-1:0]         wdata;
  // Read ports
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*XLEN-1:0]     rdata;
  // Dump stream
  logic                    dump_start;
  logic                    dump_busy;
  logic                    dump_valid;
  logic                    dump_ready;
  logic [ADDR_W-1:0]       dump_idx;
  logic [XLEN-1:0]         dump_data;
  logic                    dump_done;

  modport master (
    output we, waddr, wdata, raddr, dump_start, dump_ready,
    input  rdata, dump_busy, dump_valid, dump_idx, dump_data, dump_done
  );

  modport slave (
    input  we, waddr, wdata, raddr, dump_start, dump_ready,
    output rdata, dump_busy, dump_valid, dump_idx, dump_data, dump_done
  );

endinterface : regfile_dbg_if

`default_nettype wire

// File: rtl/regfile_dbg_dump_fsm.sv
// ============================================================================
// Module : regfile_dump_fsm
// Brief  : Serial dump engine. Walks register indices 0..NREGS-1 and emits
//          one (index, value) beat per accepted handshake. Register values
//          are fetched through an internal read port owned by the top.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_fsm
  import regfile_dbg_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_start,
  input  wire logic              i_ready,
  input  wire logic [XLEN-1:0]   i_rd_data,
  output logic      [ADDR_W-1:0] o_rd_idx,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic      [ADDR_W-1:0] o_idx,
  output logic      [XLEN-1:0]   o_data,
  output logic                   o_done
);

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NREGS - 1);

  dump_state_e       r_state;
  dump_state_e       w_state_nxt;
  logic              r_valid;
  logic [ADDR_W-1:0] r_idx;
  logic [XLEN-1:0]   r_data;
  logic              w_load;
  logic              w_adv;
  logic              w_last;

  // State register; reset aborts any dump in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and beat control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SEND;
          w_load      = 1'b1;
        end
      end
      ST_SEND: begin
        if (r_valid && i_ready) begin
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = ST_DONE;
            w_last      = 1'b1;
          end else begin
            w_adv       = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // start requests arriving here are dropped
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Index of the register to capture on the next load/advance edge
  always_comb begin
    o_rd_idx = '0;
    if (r_state != ST_IDLE) o_rd_idx = r_idx + ADDR_W'(1);
  end

  // Beat registers: captured value is frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_idx   <= '0;
      r_data  <= i_rd_data;
    end else if (w_adv) begin
      r_idx   <= r_idx + ADDR_W'(1);
      r_data  <= i_rd_data;
    end else if (w_last) begin
      r_valid <= 1'b0;
    end
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_valid = r_valid;
  assign o_idx   = r_idx;
  assign o_data  = r_data;
  assign o_done  = (r_state == ST_DONE);

endmodule : regfile_dump_fsm

`default_nettype wire

// File: rtl/regfile_dbg.sv
// ============================================================================
// Module : regfile_dbg
// Brief  : Integer register file, NRD combinational read ports, one
//          synchronous write port, x0 hard-wired to zero, plus a serial
//          valid/ready dump stream of all registers.
//          Optional macro REGFILE_BYPASS_EN: write-through forwarding of the
//          write port into read ports and dump captures.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dbg
  import regfile_dbg_pkg::*;
#(
  parameter  int XLEN   = C_DEF_XLEN,
  parameter  int NREGS  = C_DEF_NREGS,
  parameter  int NRD    = C_DEF_NRD,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input wire logic clk,
  input wire logic rst,
  regfile_dbg_if.slave bus
);

  // Port NRD is the internal read port used by the dump engine
  localparam int C_NPORT = NRD + 1;

  logic [XLEN-1:0]   r_regs   [NREGS];
  logic [ADDR_W-1:0] w_rd_addr[C_NPORT];
  logic [XLEN-1:0]   w_rd_val [C_NPORT];
  logic [ADDR_W-1:0] w_dump_rd_idx;
  logic              w_wr_en;

  // x0 is never written, so it keeps its reset value of zero
  assign w_wr_en = bus.we && (bus.waddr != '0);

  // Storage array with synchronous write and asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // External read port address unpacking and result packing
  for (genvar g = 0; g < NRD; g++) begin : g_ext_rd
    assign w_rd_addr[g] = bus.raddr[g*ADDR_W +: ADDR_W];
    assign bus.rdata[g*XLEN +: XLEN] = w_rd_val[g];
  end

  assign w_rd_addr[NRD] = w_dump_rd_idx;

  // Read muxes shared by the external ports and the dump capture port
  for (genvar g = 0; g < C_NPORT; g++) begin : g_rd_mux
    // Zero for x0, optionally forward same-cycle write data
    always_comb begin
      w_rd_val[g] = r_regs[w_rd_addr[g]];
      if (w_rd_addr[g] == '0) w_rd_val[g] = '0;
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (bus.waddr == w_rd_addr[g])) w_rd_val[g] = bus.wdata;
`endif
    end
  end

  regfile_dump_fsm #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .i_start   (bus.dump_start),
    .i_ready   (bus.dump_ready),
    .i_rd_data (w_rd_val[NRD]),
    .o_rd_idx  (w_dump_rd_idx),
    .o_busy    (bus.dump_busy),
    .o_valid   (bus.dump_valid),
    .o_idx     (bus.dump_idx),
    .o_data    (bus.dump_data),
    .o_done    (bus.dump_done)
  );

endmodule : regfile_dbg

`default_nettype wire
